fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 br_taken  in  1  EX redirect request; br_target  in  32  redirect address.
REQ-005 stall  in  1  decode not accepting; output entry held while if_valid=1.
REQ-006 predict_taken  in  1, predict_pc  in  32  BPU result for the current imem_addr, sampled on grant.
REQ-007 imem_req  out  1, imem_addr  out  32  request; imem_gnt  in  1  accept.
REQ-008 imem_rvalid  in  1, imem_rdata  in  32  response; no backpressure.
REQ-009 if_valid  out  1, if_inst/if_pc/if_pc4/if_predict_pc  out  32 each, if_predict_taken  out  1  registered fetch entry.

Function
REQ-010 FSM states SHALL be REQ, WAIT, HOLD, FLUSH; at most one memory request outstanding.
REQ-011 REQ: imem_req=1, imem_addr=pc_q; on imem_gnt, latch pc_q, predict_taken and predict_pc into the in-flight slot, then go to WAIT.
REQ-012 pc_q SHALL become predict_pc on grant when predict_taken=1, else pc_q+4 (modulo 2^32).
REQ-013 imem_addr SHALL stay stable while imem_req=1 and imem_gnt=0, except on redirect.
REQ-014 WAIT with imem_rvalid: if if_valid=0 or stall=0, the output entry SHALL load {rdata, slot pc, pc+4, slot prediction} with if_valid=1 next cycle, then go to REQ.
REQ-015 WAIT with imem_rvalid while if_valid=1 and stall=1: response SHALL go to the skid entry, then go to HOLD.
REQ-016 HOLD: imem_req=0; when stall=0, skid SHALL move to the output entry, then go to REQ.
REQ-017 Output entry with if_valid=1 and stall=1 SHALL hold all if_* values unchanged.
REQ-018 if_valid=1 with stall=0 and no new entry loading: if_valid SHALL clear next cycle.
REQ-019 Latency: rvalid in cycle N, if_valid=1 in cycle N+1; grant to next request at least 2 cycles.
REQ-020 Redirect (br_taken=1) SHALL take priority over stall, grant and response. Next cycle: pc_q=br_target with bits[1:0] forced to 0, if_valid=0, skid cleared.
REQ-021 Redirect in WAIT without rvalid, or in REQ with imem_gnt=1, SHALL go to FLUSH. Redirect in REQ without grant, WAIT with rvalid, or HOLD SHALL go to REQ.
REQ-022 FLUSH: imem_req=0; the next imem_rvalid SHALL be discarded, then go to REQ.
REQ-023 Redirect in FLUSH SHALL update pc_q and stay in FLUSH.
REQ-024 Back-to-back redirects: the last br_target SHALL win.

Reset
REQ-025 While rst=1: state=REQ, pc_q=RESET_PC, imem_req=0, if_valid=0, skid empty, all data outputs 0.
REQ-026 First cycle after rst falls: imem_req=1, imem_addr=RESET_PC.
REQ-027 Reset mid-request: any later rvalid for the pre-reset request is outside the memory contract; memory SHALL be reset with the core.

Structure
REQ-028 if_stage_pkg SHALL hold fetch_state_e {REQ, WAIT, HOLD, FLUSH} and packed fetch_entry_t {inst, pc, pc4, predict_taken, predict_pc}.
REQ-029 The one-entry skid buffer SHALL be sub-module fetch_skid (load/unload/clear, fetch_entry_t payload); the FSM and PC logic stay in fetch_ctrl.

Verification
REQ-030 Reset release, gnt same cycle, rvalid next cycle with rdata=0x00000013 -> entry {inst=0x13, pc=0x0, pc4=0x4}, next imem_addr=0x4.
REQ-031 Grant at 0x10 with predict_taken=1, predict_pc=0x80 -> next imem_addr=0x80; entry for 0x10 carries if_predict_taken=1, if_predict_pc=0x80.
REQ-032 Stall held 5 cycles while entry 0x4 valid, then rvalid for 0x8 -> HOLD, imem_req=0, 0x4 held. Stall drop -> 0x4 accepted, entry 0x8 next cycle.
REQ-033 br_taken=1, br_target=0x203 in WAIT -> FLUSH; next rvalid dropped (if_valid stays 0); next imem_addr=0x200.
REQ-034 br_taken with stall=1 and skid full -> if_valid=0, skid empty, imem_addr=br_target.
REQ-035 pc_q=0xFFFF_FFFC granted, no prediction -> next imem_addr=0x0 and if_pc4=0x0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage.
// Ports: none (package). Provides the fetch FSM state encoding, the packed
// fetch entry carried from memory response to decode, and a PC alignment helper.
package if_stage_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        predict_taken;
    logic [31:0] predict_pc;
  } fetch_entry_t;

  // Redirect targets are word-aligned by dropping the two low bits.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that parks a fetch response while decode is stalled.
// Latency: load visible on dout next cycle. Backpressure: none; caller only loads when empty.
// Ports: clk/rst, load (capture din), unload (release entry), clear (flush),
//        din/dout fetch_entry_t payload, full (entry present).
module fetch_skid
  import if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, single outstanding imem request,
// registered fetch entry toward decode with a one-entry skid for stalls.
// Latency: rvalid in cycle N -> if_valid in N+1. Backpressure: stall holds the
// output entry; a response arriving under stall is parked and requests pause.
// Ports: clk/rst, br_taken/br_target (EX redirect), stall (decode busy),
//        predict_taken/predict_pc (BPU result for imem_addr), imem_* (memory
//        request/response), if_* (registered fetch entry).
module fetch_ctrl
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  input  logic        predict_taken,
  input  logic [31:0] predict_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_predict_pc,
  output logic        if_predict_taken
);

  fetch_state_e state;
  logic [31:0]  pc_q;

  // In-flight slot: context of the request that memory has accepted.
  logic [31:0]  slot_pc;
  logic         slot_pt;
  logic [31:0]  slot_ppc;

  fetch_entry_t out_q;
  fetch_entry_t resp;
  fetch_entry_t skid_dout;
  logic         skid_full;
  logic         skid_load;
  logic         skid_unload;

  always_comb begin
    resp               = '0;
    resp.inst          = imem_rdata;
    resp.pc            = slot_pc;
    resp.pc4           = slot_pc + 32'd4;
    resp.predict_taken = slot_pt;
    resp.predict_pc    = slot_ppc;
  end

  // Request is suppressed while reset is asserted even though the state
  // register already reads REQ, so it rises the first cycle after release.
  assign imem_req  = (state == REQ) && !rst;
  assign imem_addr = pc_q;

  assign skid_load   = !br_taken && (state == WAIT) && imem_rvalid && if_valid && stall;
  assign skid_unload = !br_taken && (state == HOLD) && !stall && skid_full;

  fetch_skid u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (br_taken),
    .din    (resp),
    .dout   (skid_dout),
    .full   (skid_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      pc_q     <= RESET_PC;
      slot_pc  <= '0;
      slot_pt  <= 1'b0;
      slot_ppc <= '0;
      out_q    <= '0;
      if_valid <= 1'b0;
    end else if (br_taken) begin
      pc_q     <= align_pc(br_target);
      if_valid <= 1'b0;
      // FLUSH only when a request is (or is about to be) outstanding whose
      // response has not yet been seen.
      unique case (state)
        REQ:     state <= imem_gnt ? FLUSH : REQ;
        WAIT:    state <= imem_rvalid ? REQ : FLUSH;
        HOLD:    state <= REQ;
        default: state <= FLUSH;
      endcase
    end else begin
      // Decode consumed the entry; overridden below if a new one loads.
      if (if_valid && !stall) if_valid <= 1'b0;

      unique case (state)
        REQ: begin
          if (imem_gnt) begin
            slot_pc  <= pc_q;
            slot_pt  <= predict_taken;
            slot_ppc <= predict_pc;
            pc_q     <= predict_taken ? predict_pc : pc_q + 32'd4;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (!if_valid || !stall) begin
              out_q    <= resp;
              if_valid <= 1'b1;
              state    <= REQ;
            end else begin
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            out_q    <= skid_dout;
            if_valid <= 1'b1;
            state    <= REQ;
          end
        end
        default: begin
          if (imem_rvalid) state <= REQ;
        end
      endcase
    end
  end

  assign if_inst          = out_q.inst;
  assign if_pc            = out_q.pc;
  assign if_pc4           = out_q.pc4;
  assign if_predict_taken = out_q.predict_taken;
  assign if_predict_pc    = out_q.predict_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        predict_taken;
  logic [31:0] predict_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_predict_pc;
  logic        if_predict_taken;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .stall            (stall),
    .predict_taken    (predict_taken),
    .predict_pc       (predict_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .if_valid         (if_valid),
    .if_inst          (if_inst),
    .if_pc            (if_pc),
    .if_pc4           (if_pc4),
    .if_predict_pc    (if_predict_pc),
    .if_predict_taken (if_predict_taken)
  );

  // One record per cycle: inputs applied that cycle and the outputs expected
  // in that same cycle (before the edge that consumes the inputs).
  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        stl;
    logic        gnt;
    logic        pt;
    logic [31:0] ppc;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic        e_pt;
    logic [31:0] e_ppc;
  } vec_t;

  localparam int NV = 36;
  vec_t tbl [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    br_taken = 0; br_target = '0; stall = 0; predict_taken = 0; predict_pc = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
  endtask

  initial begin
    //          br tgt          stl gnt pt ppc   rv rdata         req addr          vld inst          pc            pc4           pt ppc
    tbl[0]  = '{0, 32'h0,        0, 1, 0, 32'h0,  0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 32'h0};
    tbl[1]  = '{0, 32'h0,        0, 0, 0, 32'h0,  1, 32'h13,       0, 32'h4,        0, 32'h0,        32'h0,        32'h0,        0, 32'h0};
    tbl[2]  = '{0, 32'h0,        0, 1, 0, 32'h0,  0, 32'h0,        1, 32'h4,        1, 32'h13,       32'h0,        32'h4,        0, 32'h0};
    tbl[3]  = '{0, 32'h0,        0, 0, 0, 32'h0,  1, 32'h11111111, 0, 32'h8,        0, 32'h13,       32'h0,        32'h4,        0, 32'h0};
    tbl[4]  = '{0, 32'h0,        1, 1, 0, 32'h0,  0, 32'h0,        1, 32'h8,        1, 32'h11111111, 32'h4,        32'h8,        0, 32'h0};
    for (int i = 5; i <= 8; i++)
      tbl[i] = '{0, 32'h0,       1, 0, 0, 32'h0,  0, 32'h0,        0, 32'hC,        1, 32'h11111111, 32'h4,        32'h8,        0, 32'h0};
    tbl[9]  = '{0, 32'h0,        1, 0, 0, 32'h0,  1, 32'h22222222, 0, 32'hC,        1, 32'h11111111, 32'h4,        32'h8,        0, 32'h0};
    tbl[10] = '{0, 32'h0,        1, 0, 0, 32'h0,  0, 32'h0,        0, 32'hC,        1, 32'h11111111, 32'h4,        32'h8,        0, 32'h0};
    tbl[11] = '{0, 32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        0, 32'hC,        1, 32'h11111111, 32'h4,        32'h8,        0, 32'h0};
    tbl[12] = '{0, 32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        1, 32'hC,        1, 32'h22222222, 32'h8,        32'hC,        0, 32'h0};
    tbl[13] = '{0, 32'h0,        0, 1, 0, 32'h0,  0, 32'h0,        1, 32'hC,        0, 32'h22222222, 32'h8,        32'hC,        0, 32'h0};
    tbl[14] = '{0, 32'h0,        0, 0, 0, 32'h0,  1, 32'h33333333, 0, 32'h10,       0, 32'h22222222, 32'h8,        32'hC,        0, 32'h0};
    tbl[15] = '{0, 32'h0,        0, 1, 1, 32'h80, 0, 32'h0,        1, 32'h10,       1, 32'h33333333, 32'hC,        32'h10,       0, 32'h0};
    tbl[16] = '{0, 32'h0,        0, 0, 0, 32'h0,  1, 32'h44444444, 0, 32'h80,       0, 32'h33333333, 32'hC,        32'h10,       0, 32'h0};
    tbl[17] = '{0, 32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        1, 32'h80,       1, 32'h44444444, 32'h10,       32'h14,       1, 32'h80};
    tbl[18] = '{0, 32'h0,        0, 1, 0, 32'h0,  0, 32'h0,        1, 32'h80,       0, 32'h44444444, 32'h10,       32'h14,       1, 32'h80};
    tbl[19] = '{1, 32'h203,      0, 0, 0, 32'h0,  0, 32'h0,        0, 32'h84,       0, 32'h44444444, 32'h10,       32'h14,       1, 32'h80};
    tbl[20] = '{0, 32'h0,        0, 0, 0, 32'h0,  1, 32'h55555555, 0, 32'h200,      0, 32'h44444444, 32'h10,       32'h14,       1, 32'h80};
    tbl[21] = '{0, 32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        1, 32'h200,      0, 32'h44444444, 32'h10,       32'h14,       1, 32'h80};
    tbl[22] = '{1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,  0, 32'h0,        1, 32'h200,      0, 32'h44444444, 32'h10,       32'h14,       1, 32'h80};
    tbl[23] = '{0, 32'h0,        0, 1, 0, 32'h0,  0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h44444444, 32'h10,       32'h14,       1, 32'h80};
    tbl[24] = '{0, 32'h0,        0, 0, 0, 32'h0,  1, 32'h66666666, 0, 32'h0,        0, 32'h44444444, 32'h10,       32'h14,       1, 32'h80};
    tbl[25] = '{0, 32'h0,        1, 0, 0, 32'h0,  0, 32'h0,        1, 32'h0,        1, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 32'h0};
    tbl[26] = '{0, 32'h0,        1, 1, 0, 32'h0,  0, 32'h0,        1, 32'h0,        1, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 32'h0};
    tbl[27] = '{0, 32'h0,        1, 0, 0, 32'h0,  1, 32'h77777777, 0, 32'h4,        1, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 32'h0};
    tbl[28] = '{1, 32'h300,      1, 0, 0, 32'h0,  0, 32'h0,        0, 32'h4,        1, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 32'h0};
    tbl[29] = '{0, 32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        1, 32'h300,      0, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 32'h0};
    tbl[30] = '{1, 32'h400,      0, 1, 0, 32'h0,  0, 32'h0,        1, 32'h300,      0, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 32'h0};
    tbl[31] = '{1, 32'h500,      0, 0, 0, 32'h0,  0, 32'h0,        0, 32'h400,      0, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 32'h0};
    tbl[32] = '{0, 32'h0,        0, 0, 0, 32'h0,  1, 32'h99,       0, 32'h500,      0, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 32'h0};
    tbl[33] = '{0, 32'h0,        0, 1, 0, 32'h0,  0, 32'h0,        1, 32'h500,      0, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 32'h0};
    tbl[34] = '{0, 32'h0,        0, 0, 0, 32'h0,  1, 32'h88888888, 0, 32'h504,      0, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 32'h0};
    tbl[35] = '{0, 32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        1, 32'h504,      1, 32'h88888888, 32'h500,      32'h504,      0, 32'h0};

    // Reset state
    drive_idle();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req",   -1, {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  -1, imem_addr, 32'h0);
    chk("rst_vld",   -1, {31'd0, if_valid}, 32'd0);
    chk("rst_inst",  -1, if_inst, 32'h0);
    chk("rst_pc",    -1, if_pc, 32'h0);
    chk("rst_pc4",   -1, if_pc4, 32'h0);
    chk("rst_ppc",   -1, if_predict_pc, 32'h0);
    chk("rst_pt",    -1, {31'd0, if_predict_taken}, 32'd0);
    rst = 0;
    #1;
    chk("rel_req",  -1, {31'd0, imem_req}, 32'd1);
    chk("rel_addr", -1, imem_addr, 32'h0);

    // Table-driven main sequence
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      br_taken = tbl[i].br;   br_target = tbl[i].tgt; stall = tbl[i].stl;
      imem_gnt = tbl[i].gnt;  predict_taken = tbl[i].pt; predict_pc = tbl[i].ppc;
      imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      #1;
      chk("imem_req",  i, {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk("imem_addr", i, imem_addr, tbl[i].e_addr);
      chk("if_valid",  i, {31'd0, if_valid}, {31'd0, tbl[i].e_vld});
      chk("if_inst",   i, if_inst, tbl[i].e_inst);
      chk("if_pc",     i, if_pc, tbl[i].e_pc);
      chk("if_pc4",    i, if_pc4, tbl[i].e_pc4);
      chk("if_pt",     i, {31'd0, if_predict_taken}, {31'd0, tbl[i].e_pt});
      chk("if_ppc",    i, if_predict_pc, tbl[i].e_ppc);
    end

    // Reset in the middle of an outstanding request, then first fetch again.
    @(negedge clk);
    drive_idle();
    imem_gnt = 1;
    @(negedge clk);
    drive_idle();
    rst = 1;
    imem_rvalid = 1;
    imem_rdata = 32'hDEADBEEF;
    #1;
    chk("mid_rst_req", 100, {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    imem_rvalid = 0;
    #1;
    chk("mid_rst_vld",  101, {31'd0, if_valid}, 32'd0);
    chk("mid_rst_addr", 101, imem_addr, 32'h0);
    chk("mid_rst_inst", 101, if_inst, 32'h0);
    chk("mid_rst_pc4",  101, if_pc4, 32'h0);
    rst = 0;
    #1;
    chk("rel2_req",  102, {31'd0, imem_req}, 32'd1);
    chk("rel2_addr", 102, imem_addr, 32'h0);
    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = 32'h00000013;
    #1;
    chk("first_wait_req",  103, {31'd0, imem_req}, 32'd0);
    chk("first_wait_addr", 103, imem_addr, 32'h4);
    @(negedge clk);
    imem_rvalid = 0;
    imem_rdata = '0;
    #1;
    chk("first_vld",  104, {31'd0, if_valid}, 32'd1);
    chk("first_inst", 104, if_inst, 32'h13);
    chk("first_pc",   104, if_pc, 32'h0);
    chk("first_pc4",  104, if_pc4, 32'h4);
    chk("first_req",  104, {31'd0, imem_req}, 32'd1);
    chk("first_addr", 104, imem_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
